gpnae_loader: RTL and testbench
===============================

# gpnae_loader

Upstream-facing loader that feeds the gpnae activation engine's input port. It accepts a burst of 32-bit samples on a valid/ready stream, writes them into gpnae one word at a time while respecting `idle_i`/`full_i`, and drives `last_o`, `terms_o` and `control_word_o`. It then counts `done_i` result pulses until the whole burst has been processed, and only then accepts the next burst.

## Interface
- `DATA_WIDTH`, 32, sample width
- `ADDR_LINES`, 5, width of the term count; a burst holds at most 2^ADDR_LINES-1 words
- `CONTROL_WIDTH`, 2, mode width (00 idle, 01 SELU, 10 sigmoid, 11 tanh)
- `TIMEOUT_CYCLES`, 4096, watchdog limit; used only with `GPNAE_LOADER_TIMEOUT_EN`

Ports:
- `clk_i`  in  1  clock; one clock domain
- `rstn_i`  in  1  reset, asynchronous, active-low
- `s_data_i`  in  DATA_WIDTH  upstream sample
- `s_valid_i`  in  1  upstream sample valid
- `s_last_i`  in  1  marks the final sample of a burst
- `s_ready_o`  out  1  loader can accept a sample
- `cfg_mode_i`  in  CONTROL_WIDTH  activation mode for the next burst
- `signal_o`  out  DATA_WIDTH  to gpnae `signal_i`
- `wr_en_o`  out  1  to gpnae `wr_en_i`
- `last_o`  out  1  to gpnae `last_i` (start)
- `terms_o`  out  ADDR_LINES  to gpnae `terms_i`
- `control_word_o`  out  CONTROL_WIDTH  to gpnae `control_word_i`
- `idle_i`, `full_i`, `done_i`  in  1 each  from gpnae
- `burst_done_o`  out  1  one-cycle pulse when the burst is fully processed
- `err_o`  out  1  sticky overflow flag; cleared only by reset
- `timeout_o`  out  1  sticky; present only with the macro

## Operation
- The FSM has states IDLE, FETCH, WAIT, WRITE, GAP, LAST, RUN.
- **IDLE:**
  - `s_ready_o` = (`cfg_mode_i` != 0).
  - On handshake: capture data and last flag, latch `cfg_mode_i` into `control_word_o`, clear the word and result counters, then go to WAIT.
- **WAIT:** go to WRITE when `idle_i && !full_i`; otherwise stay.
- **WRITE:**
  - `wr_en_o` = 1 for exactly one cycle, with `signal_o` = the held sample.
  - The word count increments by 1. Go to GAP.
- **GAP:**
  - `wr_en_o` = 0.
  - Go to LAST if the held last flag is set or the word count equals 2^ADDR_LINES-1; otherwise go to FETCH.
  - If the count reached the maximum without `s_last_i`, set `err_o`.
  - Any upstream samples still pending belong to the next burst.
- **FETCH:** `s_ready_o` = 1; on handshake capture the sample, then go to WAIT.
- **LAST:** `terms_o` = word count and `last_o` = 1; go to RUN.
- **RUN:**
  - `last_o` stays high.
  - Each `done_i` cycle increments the result count. When the result count equals the word count, pulse `burst_done_o`, drop `last_o`, set `control_word_o` = 0, and go to IDLE.
- `done_i` is counted in WAIT through RUN and ignored in IDLE.
- A `done_i` arriving in the same cycle as the LAST→RUN transition is counted.
- Counters are ADDR_LINES wide; no wrap is possible because the word count is capped.

## Timing
- All outputs are registered. Reset value of every output is 0, with `s_ready_o` = 0 during reset.
- Asserting `rstn_i` mid-burst forces IDLE immediately. Partial writes are abandoned and no `burst_done_o` is generated.
- Per-word cost is 4 cycles minimum: accept, WAIT, WRITE, GAP. The first `wr_en_o` comes 2 cycles after the accepting edge when `idle_i` is high.
- `last_o` rises 1 cycle after the final GAP.
- `burst_done_o` comes 1 cycle after the cycle in which the final `done_i` is sampled.
- `wr_en_o` is never high while `full_i` or `!idle_i` was sampled in the preceding WAIT cycle.
- `s_ready_o` is never high outside IDLE/FETCH.

## Configuration
- `GPNAE_LOADER_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT and RUN and resets on each state entry.
  - Reaching TIMEOUT_CYCLES sets `timeout_o`, drops `last_o`/`wr_en_o`, and returns the FSM to IDLE without `burst_done_o`.
- Undefined: no counter, `timeout_o` port absent, and WAIT/RUN wait indefinitely.

## Test plan
- 30-word SELU burst (mode 01), `idle_i`=1, `full_i`=0, 30 `done_i` pulses → 30 `wr_en_o` pulses 4 cycles apart; `terms_o`=30; `last_o` high until the 30th done; one `burst_done_o`; `control_word_o`=01 during the burst.
- `idle_i` low for 5 cycles before the third word → `wr_en_o` delayed exactly 5 cycles, data unchanged, no word lost or duplicated.
- 32 words with no `s_last_i` → the 31st word is forced last, `terms_o`=31, `err_o`=1; the 32nd word is accepted as the first word of the next burst.
- `cfg_mode_i`=00 with `s_valid_i`=1 → `s_ready_o` stays 0 and no writes occur. Changing `cfg_mode_i` mid-burst from 10 to 11 → `control_word_o` holds 10.
- Reset asserted during RUN after 12 of 30 dones → all outputs 0 immediately. The next burst is written from a zero count with `terms_o` correct.
- With the macro, `done_i` never arrives and TIMEOUT_CYCLES=64 → `timeout_o`=1 64 cycles after entering RUN, FSM in IDLE, `s_ready_o` high again.

Source files
------------

// File: rtl/gpnae_loader.sv
// gpnae_loader: stream-to-gpnae burst loader.
// Takes a burst of samples over valid/ready and writes them one word at a
// time into gpnae. It then raises last_o with the term count and waits for
// one done_i per written word before taking the next burst.
// Optional watchdog: define GPNAE_LOADER_TIMEOUT_EN to add the timeout_o port
// and abort bursts that stall in WAIT or RUN for TIMEOUT_CYCLES cycles.
module gpnae_loader #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_LINES     = 5,
   parameter int unsigned CONTROL_WIDTH  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic [DATA_WIDTH-1:0]    s_data_i,
   input  logic                     s_valid_i,
   input  logic                     s_last_i,
   output logic                     s_ready_o,
   input  logic [CONTROL_WIDTH-1:0] cfg_mode_i,
   output logic [DATA_WIDTH-1:0]    signal_o,
   output logic                     wr_en_o,
   output logic                     last_o,
   output logic [ADDR_LINES-1:0]    terms_o,
   output logic [CONTROL_WIDTH-1:0] control_word_o,
   input  logic                     idle_i,
   input  logic                     full_i,
   input  logic                     done_i,
   output logic                     burst_done_o,
   output logic                     err_o
`ifdef GPNAE_LOADER_TIMEOUT_EN
   ,
   output logic                     timeout_o
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_WRITE,
      ST_GAP,
      ST_LAST,
      ST_RUN
   } state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   hold_data;
   logic                    hold_last;
   logic [ADDR_LINES-1:0]   word_cnt;
   logic [ADDR_LINES-1:0]   res_cnt;
   logic [ADDR_LINES-1:0]   res_next;
   logic                    accept;
   logic                    word_max;
   logic                    results_all;

`ifdef GPNAE_LOADER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_hit;
`endif

   // Handshake, result-count lookahead and burst-limit decode.
   always_comb begin
      accept      = s_ready_o && s_valid_i;
      res_next    = res_cnt + ADDR_LINES'(done_i);
      word_max    = (word_cnt == '1);
      // Results may already all be in on RUN entry, or complete this cycle.
      results_all = (res_cnt == word_cnt) || (res_next == word_cnt);
   end

`ifdef GPNAE_LOADER_TIMEOUT_EN
   // Watchdog: counts cycles spent in WAIT or RUN, cleared in every other
   // state so each entry into WAIT/RUN starts from zero.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         tmo_cnt <= '0;
      end else if (state == ST_WAIT || state == ST_RUN) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
         tmo_cnt <= '0;
      end
   end

   // Timeout decode; fires on the TIMEOUT_CYCLES-th cycle in the state.
   always_comb begin
      tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   end
`endif

   // Loader FSM; every output is a register updated by the current state.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state          <= ST_IDLE;
         hold_data      <= '0;
         hold_last      <= 1'b0;
         word_cnt       <= '0;
         res_cnt        <= '0;
         s_ready_o      <= 1'b0;
         signal_o       <= '0;
         wr_en_o        <= 1'b0;
         last_o         <= 1'b0;
         terms_o        <= '0;
         control_word_o <= '0;
         burst_done_o   <= 1'b0;
         err_o          <= 1'b0;
`ifdef GPNAE_LOADER_TIMEOUT_EN
         timeout_o      <= 1'b0;
`endif
      end else begin
         wr_en_o      <= 1'b0;
         burst_done_o <= 1'b0;

         // Results are tallied everywhere except IDLE so early done_i pulses
         // (including one on the LAST->RUN edge) are never lost.
         if (state != ST_IDLE) begin
            res_cnt <= res_next;
         end

         case (state)
            ST_IDLE: begin
               s_ready_o <= (cfg_mode_i != '0);
               if (accept) begin
                  hold_data      <= s_data_i;
                  hold_last      <= s_last_i;
                  control_word_o <= cfg_mode_i;
                  word_cnt       <= '0;
                  res_cnt        <= '0;
                  s_ready_o      <= 1'b0;
                  state          <= ST_WAIT;
               end
            end

            ST_FETCH: begin
               if (accept) begin
                  hold_data <= s_data_i;
                  hold_last <= s_last_i;
                  s_ready_o <= 1'b0;
                  state     <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (idle_i && !full_i) begin
                  state <= ST_WRITE;
`ifdef GPNAE_LOADER_TIMEOUT_EN
               end else if (tmo_hit) begin
                  timeout_o      <= 1'b1;
                  last_o         <= 1'b0;
                  control_word_o <= '0;
                  state          <= ST_IDLE;
`endif
               end
            end

            ST_WRITE: begin
               wr_en_o  <= 1'b1;
               signal_o <= hold_data;
               word_cnt <= word_cnt + ADDR_LINES'(1);
               state    <= ST_GAP;
            end

            ST_GAP: begin
               if (hold_last || word_max) begin
                  if (!hold_last) begin
                     err_o <= 1'b1;
                  end
                  state <= ST_LAST;
               end else begin
                  s_ready_o <= 1'b1;
                  state     <= ST_FETCH;
               end
            end

            ST_LAST: begin
               terms_o <= word_cnt;
               last_o  <= 1'b1;
               state   <= ST_RUN;
            end

            ST_RUN: begin
               if (results_all) begin
                  burst_done_o   <= 1'b1;
                  last_o         <= 1'b0;
                  control_word_o <= '0;
                  state          <= ST_IDLE;
`ifdef GPNAE_LOADER_TIMEOUT_EN
               end else if (tmo_hit) begin
                  timeout_o      <= 1'b1;
                  last_o         <= 1'b0;
                  control_word_o <= '0;
                  state          <= ST_IDLE;
`endif
               end
            end

            default: begin
               s_ready_o <= 1'b0;
               last_o    <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpnae_loader.sv
// Directed self-checking bench for gpnae_loader (default build, no watchdog).
module tb_gpnae_loader;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic [31:0] s_data_i;
   logic        s_valid_i;
   logic        s_last_i;
   logic        s_ready_o;
   logic [1:0]  cfg_mode_i;
   logic [31:0] signal_o;
   logic        wr_en_o;
   logic        last_o;
   logic [4:0]  terms_o;
   logic [1:0]  control_word_o;
   logic        idle_i;
   logic        full_i;
   logic        done_i;
   logic        burst_done_o;
   logic        err_o;
`ifdef GPNAE_LOADER_TIMEOUT_EN
   logic        timeout_o;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int bd_cnt = 0;
   int last_acc = 0;
   logic [31:0] wq[$];
   int          wt[$];

   gpnae_loader #(
      .DATA_WIDTH(32),
      .ADDR_LINES(5),
      .CONTROL_WIDTH(2),
      .TIMEOUT_CYCLES(4096)
   ) dut (
      .clk_i(clk_i),
      .rstn_i(rstn_i),
      .s_data_i(s_data_i),
      .s_valid_i(s_valid_i),
      .s_last_i(s_last_i),
      .s_ready_o(s_ready_o),
      .cfg_mode_i(cfg_mode_i),
      .signal_o(signal_o),
      .wr_en_o(wr_en_o),
      .last_o(last_o),
      .terms_o(terms_o),
      .control_word_o(control_word_o),
      .idle_i(idle_i),
      .full_i(full_i),
      .done_i(done_i),
      .burst_done_o(burst_done_o),
      .err_o(err_o)
`ifdef GPNAE_LOADER_TIMEOUT_EN
      ,
      .timeout_o(timeout_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Record every write and every burst_done pulse, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (wr_en_o) begin
         wq.push_back(signal_o);
         wt.push_back(cyc);
      end
      if (burst_done_o) bd_cnt <= bd_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // Offer one sample; returns at the negedge after the accepting edge.
   task automatic send_word(input logic [31:0] d, input logic l);
      int n = 0;
      s_data_i  = d;
      s_last_i  = l;
      s_valid_i = 1'b1;
      while (!s_ready_o && n < 400) begin
         @(negedge clk_i);
         n++;
      end
      checks++;
      if (s_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL send_word_accept: s_ready=%b required 1 for data %h", s_ready_o, d);
         s_valid_i = 1'b0;
         return;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      last_acc  = cyc;
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
   endtask

   task automatic wait_last(output int rise);
      int n = 0;
      while (!last_o && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      rise = cyc;
      checks++;
      if (last_o !== 1'b1) begin
         errors++;
         $display("FAIL wait_last: last_o=%b required 1", last_o);
      end
   endtask

   task automatic pulse_dones(input int n);
      for (int i = 0; i < n; i++) begin
         done_i = 1'b1;
         @(negedge clk_i);
         done_i = 1'b0;
         @(negedge clk_i);
      end
   endtask

   // Final done of a burst, checking the completion response.
   task automatic final_done(input string tag);
      checks++;
      if (last_o !== 1'b1) begin
         errors++;
         $display("FAIL %s_last_before_final: last_o=%b required 1", tag, last_o);
      end
      done_i = 1'b1;
      @(negedge clk_i);
      done_i = 1'b0;
      checks++;
      if ({burst_done_o, last_o, control_word_o} !== 4'b1000) begin
         errors++;
         $display("FAIL %s_complete: done/last/cw=%b%b%b required 1000", tag, burst_done_o, last_o, control_word_o);
      end
      @(negedge clk_i);
      checks++;
      if (burst_done_o !== 1'b0) begin
         errors++;
         $display("FAIL %s_done_pulse: burst_done=%b required 0", tag, burst_done_o);
      end
   endtask

   task automatic test_reset;
      rstn_i = 1'b0; s_data_i = '0; s_valid_i = 1'b0; s_last_i = 1'b0;
      cfg_mode_i = 2'b00; idle_i = 1'b1; full_i = 1'b0; done_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checks++;
      if ({s_ready_o, wr_en_o, last_o, burst_done_o, err_o} !== 5'b0 ||
          signal_o !== 32'h0 || terms_o !== 5'h0 || control_word_o !== 2'b00) begin
         errors++;
         $display("FAIL reset_values: rdy=%b wr=%b last=%b bd=%b err=%b sig=%h terms=%h cw=%b required all 0",
                  s_ready_o, wr_en_o, last_o, burst_done_o, err_o, signal_o, terms_o, control_word_o);
      end
      rstn_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (s_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL ready_mode0: s_ready=%b required 0", s_ready_o);
      end
      cfg_mode_i = 2'b01;
      @(negedge clk_i);
      checks++;
      if (s_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL ready_mode1: s_ready=%b required 1", s_ready_o);
      end
   endtask

   task automatic test_selu_burst;
      int base = wq.size();
      int acc0, rise, bad, bd0;
      cfg_mode_i = 2'b01;
      bd0 = bd_cnt;
      for (int i = 0; i < 30; i++) begin
         send_word(32'h1000_0000 + i * 32'h0001_0003, (i == 29));
         if (i == 0) acc0 = last_acc;
      end
      wait_last(rise);
      checks++;
      if (wq.size() !== base + 30) begin
         errors++;
         $display("FAIL selu_write_count: got %0d required 30", wq.size() - base);
      end
      for (int i = 0; i < 30 && base + i < wq.size(); i++) begin
         checks++;
         if (wq[base + i] !== 32'h1000_0000 + i * 32'h0001_0003) begin
            errors++;
            $display("FAIL selu_data[%0d]: got %h required %h", i, wq[base + i], 32'h1000_0000 + i * 32'h0001_0003);
         end
      end
      if (wq.size() >= base + 30) begin
         checks++;
         if (wt[base] - acc0 !== 2) begin
            errors++;
            $display("FAIL first_write_latency: got %0d required 2", wt[base] - acc0);
         end
         bad = 0;
         for (int i = 1; i < 30; i++) if (wt[base + i] - wt[base + i - 1] != 4) bad++;
         checks++;
         if (bad !== 0) begin
            errors++;
            $display("FAIL selu_spacing: %0d gaps not 4 cycles, required 0", bad);
         end
         checks++;
         if (rise - wt[base + 29] !== 2) begin
            errors++;
            $display("FAIL last_rise_delay: got %0d required 2", rise - wt[base + 29]);
         end
      end
      checks++;
      if (terms_o !== 5'd30 || control_word_o !== 2'b01) begin
         errors++;
         $display("FAIL selu_terms_cw: terms=%0d cw=%b required 30 01", terms_o, control_word_o);
      end
      pulse_dones(29);
      final_done("selu");
      checks++;
      if (bd_cnt - bd0 !== 1) begin
         errors++;
         $display("FAIL selu_done_count: got %0d required 1", bd_cnt - bd0);
      end
   endtask

   task automatic test_idle_stall;
      int base = wq.size();
      int rise, acc3;
      cfg_mode_i = 2'b10;
      send_word(32'hAAAA_0001, 1'b0);
      send_word(32'hAAAA_0002, 1'b0);
      send_word(32'hAAAA_0003, 1'b0);
      acc3 = last_acc;
      idle_i = 1'b0;
      repeat (5) @(negedge clk_i);
      idle_i = 1'b1;
      send_word(32'hAAAA_0004, 1'b1);
      wait_last(rise);
      checks++;
      if (wq.size() !== base + 4) begin
         errors++;
         $display("FAIL stall_write_count: got %0d required 4", wq.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wq[base + i] !== 32'hAAAA_0001 + i) begin
               errors++;
               $display("FAIL stall_data[%0d]: got %h required %h", i, wq[base + i], 32'hAAAA_0001 + i);
            end
         end
         checks++;
         if (wt[base + 2] - acc3 !== 7 || wt[base + 2] - wt[base + 1] !== 9 || wt[base + 3] - wt[base + 2] !== 4) begin
            errors++;
            $display("FAIL stall_timing: lat=%0d gap12=%0d gap23=%0d required 7 9 4",
                     wt[base + 2] - acc3, wt[base + 2] - wt[base + 1], wt[base + 3] - wt[base + 2]);
         end
      end
      checks++;
      if (terms_o !== 5'd4) begin
         errors++;
         $display("FAIL stall_terms: got %0d required 4", terms_o);
      end
      pulse_dones(3);
      final_done("stall");
   endtask

   task automatic test_done_on_last;
      cfg_mode_i = 2'b11;
      send_word(32'h5555_0000, 1'b0);
      send_word(32'h5555_0001, 1'b1);
      repeat (2) @(negedge clk_i);
      checks++;
      if (wr_en_o !== 1'b1) begin
         errors++;
         $display("FAIL dol_wr_en: wr_en=%b required 1", wr_en_o);
      end
      @(negedge clk_i);
      done_i = 1'b1;
      @(negedge clk_i);
      done_i = 1'b0;
      checks++;
      if ({last_o, burst_done_o, terms_o} !== {1'b1, 1'b0, 5'd2}) begin
         errors++;
         $display("FAIL dol_run_entry: last=%b bd=%b terms=%0d required 1 0 2", last_o, burst_done_o, terms_o);
      end
      @(negedge clk_i);
      final_done("dol");
   endtask

   task automatic test_overflow;
      int base = wq.size();
      int rise;
      cfg_mode_i = 2'b01;
      for (int i = 0; i < 31; i++) send_word(32'hC000_0000 + i, 1'b0);
      s_data_i  = 32'hC000_001F;
      s_last_i  = 1'b1;
      s_valid_i = 1'b1;
      wait_last(rise);
      checks++;
      if (terms_o !== 5'd31 || err_o !== 1'b1 || s_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL overflow_state: terms=%0d err=%b rdy=%b required 31 1 0", terms_o, err_o, s_ready_o);
      end
      checks++;
      if (wq.size() !== base + 31) begin
         errors++;
         $display("FAIL overflow_count: got %0d required 31", wq.size() - base);
      end
      pulse_dones(30);
      final_done("overflow");
      send_word(32'hC000_001F, 1'b1);
      wait_last(rise);
      checks++;
      if (terms_o !== 5'd1 || wq.size() !== base + 32 || err_o !== 1'b1) begin
         errors++;
         $display("FAIL next_burst: terms=%0d writes=%0d err=%b required 1 32 1", terms_o, wq.size() - base, err_o);
      end else begin
         checks++;
         if (wq[base + 31] !== 32'hC000_001F) begin
            errors++;
            $display("FAIL next_burst_data: got %h required c000001f", wq[base + 31]);
         end
      end
      final_done("next_burst");
   endtask

   task automatic test_mode;
      int base, rise, bad;
      cfg_mode_i = 2'b00;
      s_valid_i  = 1'b0;
      @(negedge clk_i);
      base = wq.size();
      s_data_i  = 32'hDEAD_BEEF;
      s_valid_i = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         if (s_ready_o) bad++;
      end
      checks++;
      if (bad !== 0 || wq.size() !== base) begin
         errors++;
         $display("FAIL mode0_blocked: ready_cycles=%0d writes=%0d required 0 0", bad, wq.size() - base);
      end
      cfg_mode_i = 2'b10;
      send_word(32'h7777_0000, 1'b0);
      cfg_mode_i = 2'b11;
      send_word(32'h7777_0001, 1'b0);
      send_word(32'h7777_0002, 1'b1);
      wait_last(rise);
      checks++;
      if (control_word_o !== 2'b10 || terms_o !== 5'd3) begin
         errors++;
         $display("FAIL mode_hold: cw=%b terms=%0d required 10 3", control_word_o, terms_o);
      end
      pulse_dones(2);
      final_done("mode");
   endtask

   task automatic test_mid_reset;
      int base, rise, bd0;
      cfg_mode_i = 2'b01;
      for (int i = 0; i < 30; i++) send_word(32'hE000_0000 + i, (i == 29));
      wait_last(rise);
      pulse_dones(12);
      bd0 = bd_cnt;
      #2 rstn_i = 1'b0;
      #1;
      checks++;
      if ({s_ready_o, wr_en_o, last_o, burst_done_o, err_o} !== 5'b0 ||
          signal_o !== 32'h0 || terms_o !== 5'h0 || control_word_o !== 2'b00) begin
         errors++;
         $display("FAIL midrun_reset: rdy=%b wr=%b last=%b bd=%b err=%b sig=%h terms=%h cw=%b required all 0",
                  s_ready_o, wr_en_o, last_o, burst_done_o, err_o, signal_o, terms_o, control_word_o);
      end
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
      base = wq.size();
      send_word(32'hF000_0001, 1'b0);
      send_word(32'hF000_0002, 1'b0);
      send_word(32'hF000_0003, 1'b1);
      wait_last(rise);
      checks++;
      if (terms_o !== 5'd3 || wq.size() !== base + 3 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_burst: terms=%0d writes=%0d err=%b required 3 3 0", terms_o, wq.size() - base, err_o);
      end else begin
         checks++;
         if (wq[base] !== 32'hF000_0001 || wq[base + 2] !== 32'hF000_0003) begin
            errors++;
            $display("FAIL post_reset_data: got %h %h required f0000001 f0000003", wq[base], wq[base + 2]);
         end
      end
      pulse_dones(2);
      final_done("post_reset");
      checks++;
      if (bd_cnt - bd0 !== 1) begin
         errors++;
         $display("FAIL reset_no_done: burst_done pulses=%0d required 1", bd_cnt - bd0);
      end
   endtask

   initial begin
      test_reset();
      test_selu_burst();
      test_idle_stall();
      test_done_on_last();
      test_overflow();
      test_mode();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
